// File: rtl/singlecycle_pkg.sv
// Shared types for the EX-stage multiply/divide unit.
// Operation encodings, FSM states and small op-class helpers.
package singlecycle_pkg;

   typedef enum logic [2:0] {
      MDU_MUL,
      MDU_MULH,
      MDU_MULHSU,
      MDU_MULHU,
      MDU_DIV,
      MDU_DIVU,
      MDU_REM,
      MDU_REMU
   } MDUSel_e;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } MduState_e;

   function automatic logic op_is_div(input MDUSel_e op);
      return op inside {MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU};
   endfunction

   function automatic logic op_is_rem(input MDUSel_e op);
      return op inside {MDU_REM, MDU_REMU};
   endfunction

   function automatic logic op_a_signed(input MDUSel_e op);
      return op inside {MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
   endfunction

   function automatic logic op_b_signed(input MDUSel_e op);
      return op inside {MDU_MULH, MDU_DIV, MDU_REM};
   endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit beside the EX-stage ALU.
// Shift-add multiply and restoring divide share one XLEN+1-bit adder.
module muldiv_unit
   import singlecycle_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_flush,
   input  logic            i_valid,
   output logic            o_ready,
   input  MDUSel_e         i_op,
   input  logic [XLEN-1:0] i_operand_a,
   input  logic [XLEN-1:0] i_operand_b,
   output logic            o_valid,
   input  logic            i_ready,
   output logic [XLEN-1:0] o_result
);

   localparam int CNT_W = $clog2(XLEN + 1);
   localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

   function automatic logic [XLEN-1:0] to_mag(
      input logic [XLEN-1:0] x,
      input logic            sgn
   );
      return (sgn && x[XLEN-1]) ? -x : x;
   endfunction

   function automatic logic [XLEN-1:0] neg_if(
      input logic [XLEN-1:0] x,
      input logic            neg
   );
      return neg ? -x : x;
   endfunction

   MduState_e        state;
   MDUSel_e          op_q;
   logic [CNT_W-1:0] cnt;
   logic [XLEN-1:0]  a_q;
   logic [XLEN-1:0]  b_q;
   logic [XLEN-1:0]  hi_q;
   logic [XLEN-1:0]  lo_q;
   logic             neg_q;
   logic             neg_r;

   logic              is_div;
   logic              is_rem;
   logic [XLEN:0]     shifted;
   logic [XLEN:0]     add_a;
   logic [XLEN:0]     add_b;
   logic [XLEN:0]     sum;
   logic              qbit;
   logic [XLEN-1:0]   hi_n;
   logic [XLEN-1:0]   lo_n;
   logic [2*XLEN-1:0] prod_s;
   logic [XLEN-1:0]   res;

   logic            in_div;
   logic            in_rem;
   logic            a_neg;
   logic            b_neg;
   logic            div_zero;
   logic            div_ovf;
   logic [XLEN-1:0] a_mag;
   logic [XLEN-1:0] b_mag;
   logic [XLEN-1:0] fast_res;

   assign o_ready = (state == IDLE);

   assign is_div = op_is_div(op_q);
   assign is_rem = op_is_rem(op_q);

   // Divide subtracts the divisor via ~b + 1; multiply adds the multiplicand.
   assign shifted = {hi_q, lo_q[XLEN-1]};
   assign add_a   = is_div ? shifted : {1'b0, hi_q};
   assign add_b   = is_div ? ~{1'b0, b_q} : {1'b0, a_q};
   assign sum     = add_a + add_b + {{XLEN{1'b0}}, is_div};
   assign qbit    = ~sum[XLEN];

   always_comb begin
      hi_n = hi_q;
      lo_n = lo_q;
      if (is_div) begin
         hi_n = qbit ? sum[XLEN-1:0] : shifted[XLEN-1:0];
         lo_n = {lo_q[XLEN-2:0], qbit};
      end else if (lo_q[0]) begin
         hi_n = sum[XLEN:1];
         lo_n = {sum[0], lo_q[XLEN-1:1]};
      end else begin
         hi_n = {1'b0, hi_q[XLEN-1:1]};
         lo_n = {hi_q[0], lo_q[XLEN-1:1]};
      end
   end

   assign prod_s = neg_q ? -{hi_n, lo_n} : {hi_n, lo_n};

   always_comb begin
      res = '0;
      unique case (1'b1)
         op_q == MDU_MUL:            res = prod_s[XLEN-1:0];
         !is_div && op_q != MDU_MUL: res = prod_s[2*XLEN-1:XLEN];
         is_div && !is_rem:          res = neg_if(lo_n, neg_q);
         is_div && is_rem:           res = neg_if(hi_n, neg_r);
         default:                    res = '0;
      endcase
   end

   assign in_div   = op_is_div(i_op);
   assign in_rem   = op_is_rem(i_op);
   assign a_neg    = op_a_signed(i_op) && i_operand_a[XLEN-1];
   assign b_neg    = op_b_signed(i_op) && i_operand_b[XLEN-1];
   assign a_mag    = to_mag(i_operand_a, op_a_signed(i_op));
   assign b_mag    = to_mag(i_operand_b, op_b_signed(i_op));
   assign div_zero = in_div && (i_operand_b == '0);
   assign div_ovf  = (i_op == MDU_DIV || i_op == MDU_REM)
                  && (i_operand_a == MIN_INT)
                  && (i_operand_b == '1);

   always_comb begin
      if (div_zero)
         fast_res = in_rem ? i_operand_a : '1;
      else
         fast_res = in_rem ? '0 : MIN_INT;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state    <= IDLE;
         op_q     <= MDU_MUL;
         cnt      <= '0;
         a_q      <= '0;
         b_q      <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         o_valid  <= 1'b0;
         o_result <= '0;
      end else if (i_flush) begin
         state   <= IDLE;
         cnt     <= '0;
         o_valid <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (i_valid) begin
                  op_q  <= i_op;
                  neg_q <= a_neg ^ b_neg;
                  neg_r <= a_neg;
                  hi_q  <= '0;
                  a_q   <= in_div ? '0 : a_mag;
                  b_q   <= in_div ? b_mag : '0;
                  lo_q  <= in_div ? a_mag : b_mag;
                  if (div_zero || div_ovf) begin
                     o_result <= fast_res;
                     o_valid  <= 1'b1;
                     cnt      <= '0;
                     state    <= DONE;
                  end else begin
                     cnt   <= CNT_W'(XLEN);
                     state <= BUSY;
                  end
               end
            end
            BUSY: begin
               hi_q <= hi_n;
               lo_q <= lo_n;
               cnt  <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  o_result <= res;
                  o_valid  <= 1'b1;
                  state    <= DONE;
               end
            end
            DONE: begin
               if (i_ready) begin
                  o_valid <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
